hazard_stall_unit: RTL
======================

// Module: hazard_stall_unit
// PURPOSE
//  ID-stage interlock for the 5-stage MIPS pipeline: the stall/flush counterpart of
//  the forwarding unit. Inserts bubbles where a value cannot be bypassed: load-use,
//  and branch operands still in flight. Interlocks a multi-cycle mult/div unit
//  (HI/LO) and keeps saturating stall/bubble statistics.
//  Drives the PC, IF/ID and ID/EX pipeline-register controls.
// PARAMETERS
//  MD_LATENCY  4   mult/div busy cycles after issue (legal 1..15)
//  CNT_W       16  width of the statistics counters
// PORTS
//  clk          in   1      clock; all state updates on posedge
//  rst          in   1      synchronous, active-high reset
//  IFIDrs       in   5      rs field of the instruction in ID
//  IFIDrt       in   5      rt field of the instruction in ID
//  useRs        in   1      ID instruction reads rs
//  useRt        in   1      ID instruction reads rt
//  branch       in   1      ID instruction is beq/bne; compared in ID
//  branchTaken  in   1      ID comparison result (valid only when not stalled)
//  mdStart      in   1      ID instruction is mult/div
//  mdRead       in   1      ID instruction is mfhi/mflo
//  IDEXmemRead  in   1      EX-stage instruction is a load
//  IDEXregWr    in   1      EX-stage instruction writes a register
//  IDEXrd       in   5      EX-stage destination (rt for loads, rd for R-type)
//  EXMEMmemRead in   1      MEM-stage instruction is a load
//  EXMEMrd      in   5      MEM-stage destination
//  pcWrite      out  1      PC update enable
//  IFIDwrite    out  1      IF/ID register load enable
//  IDEXbubble   out  1      zero ID/EX control fields this cycle (insert NOP)
//  IFIDflush    out  1      squash the fetched instruction (taken branch)
//  mdBusy       out  1      mult/div unit busy
//  stallCount   out  CNT_W  cycles with stall=1, saturating
//  bubbleCount  out  CNT_W  stall episodes (rising edges of stall), saturating
// BEHAVIOUR
//  Define match(r) = (r != 0) && ((useRs && r == IFIDrs) || (useRt && r == IFIDrt)).
//  Hazard terms (combinational, from current inputs):
//   LU  = IDEXmemRead && match(IDEXrd)
//   BEX = branch && IDEXregWr && !IDEXmemRead && match(IDEXrd)
//   BLD = branch && (IDEXmemRead && match(IDEXrd) || EXMEMmemRead && match(EXMEMrd))
//   MD  = (mdRead || mdStart) && mdCnt != 0
//  stall = !rst && (LU || BEX || BLD || MD).
//  A load feeding a branch therefore stalls 2 cycles: first via IDEX, then via EXMEM.
//  Outputs: pcWrite = IFIDwrite = !stall; IDEXbubble = stall;
//   IFIDflush = branch && branchTaken && !stall (a stalled branch never flushes).
//  mdCnt (4 bit):
//   - rst -> 0.
//   - If mdStart && !stall, load MD_LATENCY.
//   - Else if mdCnt != 0, decrement.
//   mdBusy = (mdCnt != 0).
//   A new mdStart while busy stalls until mdCnt==0, then issues in that cycle.
//  Statistics: prevStall register (rst -> 0) holds last cycle's stall.
//   stallCount++ when stall; bubbleCount++ when stall && !prevStall.
//   Both hold at 2^CNT_W-1 (no wrap); rst -> 0.
//  Reset values (while rst=1): pcWrite=1, IFIDwrite=1, IDEXbubble=0, IFIDflush=0,
//   mdBusy=0, stallCount=0, bubbleCount=0. Reset mid-mult/div abandons it (mdCnt=0).
//  Register 0 never causes a hazard. Simultaneous hazards produce one stall cycle,
//   not an accumulated count; they are re-evaluated every cycle.
// TESTING
//  1 lw $2 in EX (IDEXmemRead=1, IDEXrd=2); add in ID, rs=2, useRs=1 ->
//    stall 1 cycle: pcWrite=0, IDEXbubble=1; next cycle (inputs advanced) stall=0.
//  2 beq rs=3 in ID, IDEX add rd=3, regWr=1, branchTaken=1 -> stall 1 cycle,
//    IFIDflush=0; next cycle IFIDflush=1, pcWrite=1.
//  3 lw rd=4 in EX, beq rt=4 in ID -> stall in 2 consecutive cycles;
//    stallCount +2, bubbleCount +1.
//  4 MD_LATENCY=4: mdStart cycle 0 -> mdCnt 4,3,2,1,0 over cycles 1..5;
//    mflo in ID from cycle 1 stalls cycles 1-4 and issues at cycle 5.
//  5 Hazard on $0 (IDEXrd=0, lw, rs=0) -> no stall.
//    rst asserted at cycle 2 of a mult/div -> mdBusy=0 and counters 0 next cycle.
//  6 CNT_W=4, hold stall for 20 cycles -> stallCount stops at 15, bubbleCount=1.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
//   ID-stage interlock for a 5-stage MIPS pipeline. It works alongside the
//   forwarding unit and stalls only where a value cannot be bypassed:
//     - load-use: a load in EX feeding the instruction in ID
//     - branch operands: branches compare in ID, so an ALU result still in EX,
//       or a load result in EX or MEM, is not yet available
//     - mult/div: the HI/LO unit is busy for MD_LATENCY cycles after issue
//   It also keeps saturating statistics on stall cycles and stall episodes.
//
// Parameters
//   MD_LATENCY  mult/div busy cycles after issue (1..15)
//   CNT_W       width of the statistics counters
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   IFIDrs, IFIDrt        source register fields of the ID instruction
//   useRs, useRt          ID instruction actually reads rs / rt
//   branch, branchTaken   ID instruction is beq/bne, and its compare result
//   mdStart, mdRead       ID instruction is mult/div, or mfhi/mflo
//   IDEXmemRead/regWr/rd  EX-stage load flag, write flag, destination
//   EXMEMmemRead/rd       MEM-stage load flag, destination
//   pcWrite, IFIDwrite    PC and IF/ID load enables (low while stalled)
//   IDEXbubble            zero the ID/EX control fields (insert a NOP)
//   IFIDflush             squash the fetched instruction on a taken branch
//   mdBusy                mult/div unit busy
//   stallCount            cycles spent stalled, saturating
//   bubbleCount           stall episodes (rising edges of stall), saturating
// ---------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IFIDrs,
    input  logic [4:0]       IFIDrt,
    input  logic             useRs,
    input  logic             useRt,
    input  logic             branch,
    input  logic             branchTaken,
    input  logic             mdStart,
    input  logic             mdRead,
    input  logic             IDEXmemRead,
    input  logic             IDEXregWr,
    input  logic [4:0]       IDEXrd,
    input  logic             EXMEMmemRead,
    input  logic [4:0]       EXMEMrd,
    output logic             pcWrite,
    output logic             IFIDwrite,
    output logic             IDEXbubble,
    output logic             IFIDflush,
    output logic             mdBusy,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] bubbleCount
);

    localparam logic [3:0]       MD_LOAD = 4'(MD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Destination of each in-flight stage that may need the ID operands:
    // index 0 is EX, index 1 is MEM.
    logic [4:0] src_rd [2];
    logic [1:0] src_match;

    assign src_rd[0] = IDEXrd;
    assign src_rd[1] = EXMEMrd;

    // $0 is hardwired to zero, so it never carries a dependency.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_match
            assign src_match[gi] = (src_rd[gi] != 5'd0) &&
                                   ((useRs && (src_rd[gi] == IFIDrs)) ||
                                    (useRt && (src_rd[gi] == IFIDrt)));
        end
    endgenerate

    logic [3:0]       md_cnt_reg;
    logic             prev_stall_reg;
    logic [CNT_W-1:0] stall_count_reg;
    logic [CNT_W-1:0] bubble_count_reg;

    logic haz_lu;
    logic haz_bex;
    logic haz_bld;
    logic haz_md;
    logic stall;

    always_comb begin
        haz_lu  = IDEXmemRead && src_match[0];
        // ALU result in EX reaches ID through the EX/MEM bypass next cycle;
        // a load in EX is covered by haz_bld instead.
        haz_bex = branch && IDEXregWr && !IDEXmemRead && src_match[0];
        // Load feeding a branch: stalls while in EX and again while in MEM.
        haz_bld = branch && ((IDEXmemRead && src_match[0]) ||
                             (EXMEMmemRead && src_match[1]));
        haz_md  = (mdRead || mdStart) && (md_cnt_reg != 4'd0);
        stall   = !rst && (haz_lu || haz_bex || haz_bld || haz_md);
    end

    assign pcWrite    = !stall;
    assign IFIDwrite  = !stall;
    assign IDEXbubble = stall;
    // The compare result is meaningless while stalled, so never flush then.
    assign IFIDflush  = !rst && branch && branchTaken && !stall;

    // Status outputs read as zero for the whole reset window, including the
    // first reset cycle before the registers have been cleared.
    assign mdBusy      = !rst && (md_cnt_reg != 4'd0);
    assign stallCount  = rst ? '0 : stall_count_reg;
    assign bubbleCount = rst ? '0 : bubble_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            md_cnt_reg       <= 4'd0;
            prev_stall_reg   <= 1'b0;
            stall_count_reg  <= '0;
            bubble_count_reg <= '0;
        end else begin
            // A mult/div waiting on a busy unit is stalled, so the counter keeps
            // draining and the new operation issues in the cycle it reaches 0.
            if (mdStart && !stall) begin
                md_cnt_reg <= MD_LOAD;
            end else if (md_cnt_reg != 4'd0) begin
                md_cnt_reg <= md_cnt_reg - 4'd1;
            end

            prev_stall_reg <= stall;

            if (stall && (stall_count_reg != CNT_MAX)) begin
                stall_count_reg <= stall_count_reg + 1'b1;
            end
            if (stall && !prev_stall_reg && (bubble_count_reg != CNT_MAX)) begin
                bubble_count_reg <= bubble_count_reg + 1'b1;
            end
        end
    end

endmodule
